c_pipe_active_ctrl: RTL and testbench



---
 rtl/c_pipe_active_ctrl_pkg.sv | 25 ++
 rtl/c_pipe_active_ctrl_if.sv | 38 +++
 rtl/c_pipe_active_ctrl_stage.sv | 35 +++
 rtl/c_pipe_active_ctrl.sv | 95 +++++++++
 tb/tb_c_pipe_active_ctrl.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/c_pipe_active_ctrl_pkg.sv
// Shared definitions for the pipeline active-enable controller: width helpers
// and the statistics counter type.
package c_pipe_ctrl_pkg;

  localparam int STAT_W = 16;
  typedef logic [STAT_W-1:0] stat_cnt_t;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

  // The idle hold counter is never narrower than one bit, even for idle_hold=0.
  function automatic int hold_cnt_w(input int idle_hold);
    return (idle_hold < 1) ? 1 : clog2(idle_hold + 1);
  endfunction

endpackage

// File: rtl/c_pipe_active_ctrl_if.sv
// Handshake, per-stage control and status bundle of c_pipe_active_ctrl.
// Stats signals exist only when C_PIPE_ACTIVE_CTRL_STATS_EN is defined.
interface c_pipe_active_ctrl_if
  import c_pipe_ctrl_pkg::*;
#(
  parameter int num_stages = 3
);
  logic                  in_valid;
  logic                  in_ready;
  logic                  out_valid;
  logic                  out_ready;
  logic                  flush;
  logic [num_stages-1:0] stage_active;
  logic [num_stages-1:0] stage_valid;
  logic                  busy;
`ifdef C_PIPE_ACTIVE_CTRL_STATS_EN
  stat_cnt_t                        stall_count;
  logic [clog2(num_stages+1)-1:0]   occupancy;

  modport master (
    output in_valid, out_ready, flush,
    input  in_ready, out_valid, stage_active, stage_valid, busy, stall_count, occupancy
  );
  modport slave (
    input  in_valid, out_ready, flush,
    output in_ready, out_valid, stage_active, stage_valid, busy, stall_count, occupancy
  );
`else
  modport master (
    output in_valid, out_ready, flush,
    input  in_ready, out_valid, stage_active, stage_valid, busy
  );
  modport slave (
    input  in_valid, out_ready, flush,
    output in_ready, out_valid, stage_active, stage_valid, busy
  );
`endif
endinterface

// File: rtl/c_pipe_active_ctrl_stage.sv
// One stage of the controller: its valid bit, its link in the ready chain and
// the load enable for the matching datapath register.
module c_pipe_stage_ctrl (
  input  logic clk,
  input  logic reset,
  input  logic src_i,
  input  logic rdy_next_i,
  input  logic flush_i,
  output logic rdy_o,
  output logic active_o,
  output logic valid_o,
  output logic valid_d_o
);
  logic valid_q, valid_d;

  assign rdy_o    = ~valid_q | rdy_next_i;
  // Only real beats load the register; bubbles, flush and reset leave it idle.
  assign active_o = rdy_o & src_i & ~(flush_i | reset);

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    valid_d = valid_q;
    if (flush_i)    valid_d = 1'b0;
    else if (rdy_o) valid_d = src_i;
  end

  // NOTE: sequential state uses non-blocking assignments; reset is asynchronous and active-high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) valid_q <= 1'b0;
    else       valid_q <= valid_d;
  end

  assign valid_o   = valid_q;
  assign valid_d_o = valid_d;
endmodule

// File: rtl/c_pipe_active_ctrl.sv
// Sequencing controller for a chain of enable-gated pipeline registers, with
// busy hold-off. Define C_PIPE_ACTIVE_CTRL_STATS_EN for stall/occupancy stats.
module c_pipe_active_ctrl
  import c_pipe_ctrl_pkg::*;
#(
  parameter int num_stages = 3,
  parameter int idle_hold  = 4
) (
  input logic              clk,
  input logic              reset,
  c_pipe_active_ctrl_if.slave bus
);
  localparam int HOLD_W = hold_cnt_w(idle_hold);
  typedef logic [HOLD_W-1:0] hold_cnt_t;
  localparam hold_cnt_t HOLD_INIT = hold_cnt_t'(idle_hold);

  logic [num_stages:0]   rdy;
  logic [num_stages-1:0] src;
  logic [num_stages-1:0] active;
  logic [num_stages-1:0] valid_q;
  logic [num_stages-1:0] valid_d;
  logic                  occ, occ_next;
  hold_cnt_t             hold_q, hold_d;
  logic                  busy_q, busy_d;

  assign rdy[num_stages] = bus.out_ready;

  for (genvar i = 0; i < num_stages; i++) begin : g_stage
    if (i == 0) begin : g_head
      assign src[i] = bus.in_valid;
    end else begin : g_body
      assign src[i] = valid_q[i-1];
    end

    c_pipe_stage_ctrl u_stage (
      .clk        (clk),
      .reset      (reset),
      .src_i      (src[i]),
      .rdy_next_i (rdy[i+1]),
      .flush_i    (bus.flush),
      .rdy_o      (rdy[i]),
      .active_o   (active[i]),
      .valid_o    (valid_q[i]),
      .valid_d_o  (valid_d[i])
    );
  end

  assign bus.in_ready     = rdy[0] & ~bus.flush;
  assign bus.out_valid    = valid_q[num_stages-1];
  assign bus.stage_active = active;
  assign bus.stage_valid  = valid_q;
  assign bus.busy         = busy_q;

  assign occ      = |valid_q;
  assign occ_next = |valid_d;

  // Hold counter reloads while occupied and drains to zero once empty.
  always_comb begin
    hold_d = hold_q;
    if (occ)                 hold_d = HOLD_INIT;
    else if (hold_q != '0)   hold_d = hold_q - hold_cnt_t'(1);
    busy_d = occ_next | (hold_d != '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_q <= '0;
      busy_q <= 1'b0;
    end else begin
      hold_q <= hold_d;
      busy_q <= busy_d;
    end
  end

`ifdef C_PIPE_ACTIVE_CTRL_STATS_EN
  localparam int OCC_W = clog2(num_stages + 1);

  stat_cnt_t        stall_q;
  logic [OCC_W-1:0] occ_cnt;

  // Saturating stall counter; flush deliberately leaves it alone.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                                stall_q <= '0;
    else if (bus.out_valid && !bus.out_ready && stall_q != '1) stall_q <= stall_q + stat_cnt_t'(1);
  end

  always_comb begin
    occ_cnt = '0;
    for (int i = 0; i < num_stages; i++) occ_cnt = occ_cnt + OCC_W'(valid_q[i]);
  end

  assign bus.stall_count = stall_q;
  assign bus.occupancy   = occ_cnt;
`endif
endmodule

// File: tb/tb_c_pipe_active_ctrl.sv
// Scoreboard bench for c_pipe_active_ctrl (3 stages, idle_hold 4); a local
// data pipeline gated by stage_active carries beat tags end to end.
module tb_c_pipe_active_ctrl;
  localparam int N    = 3;
  localparam int HOLD = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] in_data;

  always #5 clk = ~clk;

  c_pipe_active_ctrl_if #(.num_stages(N)) bus ();

  c_pipe_active_ctrl #(.num_stages(N), .idle_hold(HOLD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: tags pushed on acceptance, popped on each downstream transfer.
  logic [7:0] sb_q[$];
  logic [7:0] data_q [N];
  int         delivered = 0;

  always @(posedge clk) begin
    if (reset) begin
      sb_q.delete();
    end else begin
      if (bus.out_valid && bus.out_ready) begin
        delivered++;
        if (sb_q.size() == 0) check("sb_underflow", 32'd1, 32'd0);
        else                  check("sb_data", {24'd0, data_q[N-1]}, {24'd0, sb_q.pop_front()});
      end
      if (bus.flush)                          sb_q.delete();
      else if (bus.in_valid && bus.in_ready)  sb_q.push_back(in_data);
      for (int i = 0; i < N; i++) begin
        if (bus.stage_active[i]) begin
          if (i == 0) data_q[i] <= in_data;
          else        data_q[i] <= data_q[i-1];
        end
      end
    end
  end

  logic [2:0] act_tbl [10] = '{3'b001, 3'b010, 3'b100, 3'b000, 3'b000,
                               3'b000, 3'b000, 3'b000, 3'b000, 3'b000};
  logic [9:0] busy_exp = 10'b00_1111_1110;
  logic [9:0] ov_exp   = 10'b00_0000_1000;

  initial begin
    int sent;
    int d0;
    logic acc;

    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.flush     = 1'b0;
    in_data       = 8'h00;
    repeat (2) tick();
    reset = 1'b0;

    // Fill, then assert reset asynchronously mid-cycle.
    bus.in_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      in_data = 8'hE0 + 8'(c);
      tick();
    end
    check("pre_rst_valid", bus.stage_valid, 3'b111);
    #2 reset = 1'b1;
    #1;
    check("rst_stage_valid", bus.stage_valid, 3'b000);
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_in_ready", bus.in_ready, 1'b1);
    check("rst_stage_active", bus.stage_active, 3'b000);
    tick();
    check("rst_hold_active", bus.stage_active, 3'b000);
    reset        = 1'b0;
    bus.in_valid = 1'b0;
    tick();

    // Single beat through an always-ready sink.
    bus.out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      bus.in_valid = (c == 0);
      in_data      = 8'hA0;
      @(negedge clk);
      check("single_active", bus.stage_active, act_tbl[c]);
      check("single_out_valid", bus.out_valid, ov_exp[c]);
      check("single_busy", bus.busy, busy_exp[c]);
      tick();
    end

    // Five beats into a stalled sink, then release.
    bus.out_ready = 1'b0;
    sent = 0;
    for (int c = 0; c < 6; c++) begin
      bus.in_valid = (sent < 5);
      in_data      = 8'h10 + 8'(sent);
      @(negedge clk);
      if (c >= 3) begin
        check("stall_in_ready", bus.in_ready, 1'b0);
        check("stall_active", bus.stage_active, 3'b000);
        check("stall_valid", bus.stage_valid, 3'b111);
      end
      acc = bus.in_valid && bus.in_ready;
      tick();
      if (acc) sent++;
    end
    check("stall_accepted", sent, 3);
    d0 = delivered;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      bus.in_valid = (sent < 5);
      in_data      = 8'h10 + 8'(sent);
      @(negedge clk);
      check("drain_out_valid", bus.out_valid, 1'b1);
      acc = bus.in_valid && bus.in_ready;
      tick();
      if (acc) sent++;
    end
    check("drain_delivered", delivered - d0, 5);
    check("drain_sent", sent, 5);
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("drain_empty", bus.stage_valid, 3'b000);
    tick();

    // Bubble collapse: beats in cycles 0 and 2 with the sink stalled.
    bus.out_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      bus.in_valid = (c == 0) || (c == 2);
      in_data      = (c == 0) ? 8'hA1 : 8'hB2;
      @(negedge clk);
      if (c == 3) begin
        check("bub_valid_c3", bus.stage_valid, 3'b101);
        check("bub_active_c3", bus.stage_active, 3'b010);
      end
      if (c >= 4) check("bub_valid", bus.stage_valid, 3'b110);
      if (c >= 3) check("bub_s2_idle", bus.stage_active[2], 1'b0);
      tick();
    end
    d0 = delivered;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) tick();
    check("bub_delivered", delivered - d0, 2);
    check("bub_empty", bus.stage_valid, 3'b000);
    repeat (6) tick();

    // Flush of a full pipe with a final downstream transfer.
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    for (int c = 0; c < 3; c++) begin
      in_data = 8'hC0 + 8'(c);
      tick();
    end
    check("pre_flush_valid", bus.stage_valid, 3'b111);
    bus.flush     = 1'b1;
    bus.out_ready = 1'b1;
    in_data       = 8'hCF;
    d0 = delivered;
    @(negedge clk);
    check("flush_in_ready", bus.in_ready, 1'b0);
    check("flush_active", bus.stage_active, 3'b000);
    check("flush_out_valid", bus.out_valid, 1'b1);
    tick();
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    check("flush_last_xfer", delivered - d0, 1);
    check("flush_cleared", bus.stage_valid, 3'b000);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("flush_busy", bus.busy, (c < 4) ? 1'b1 : 1'b0);
      tick();
    end

`ifdef C_PIPE_ACTIVE_CTRL_STATS_EN
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("stats_rst", bus.stall_count, 16'd0);
    for (int c = 0; c < 13; c++) begin
      bus.in_valid = (c < 3);
      in_data      = 8'hD0 + 8'(c);
      tick();
    end
    bus.in_valid  = 1'b0;
    bus.flush     = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("stats_stall", bus.stall_count, 16'd10);
    check("stats_occ", bus.occupancy, 2'd3);
    tick();
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    check("stats_occ_flushed", bus.occupancy, 2'd0);
    check("stats_stall_kept", bus.stall_count, 16'd10);
    tick();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
